// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
// Module   : div_seq
// Purpose  : Parametrised sequential restoring radix-2 integer divider.
//            One quotient bit per clock, runtime signed/unsigned selection,
//            start/busy/done handshake, defined divide-by-zero and signed
//            overflow results. Sits beside the PRNG core for modulo
//            reduction and range scaling.
// Ports    : clk, rst (sync, active-high)
//            start, signed_mode, dividend, divisor   - request, sampled when idle
//            busy                                    - operation in progress
//            done                                    - one-cycle result strobe
//            q, r, div_by_zero                       - held until next done
// Options  : DIV_SEQ_EARLY_EXIT_EN - when defined, an operation whose dividend
//            magnitude is below the divisor magnitude skips the iteration
//            phase and completes one edge after accept.
// Revision : 1.0 - initial release
// ============================================================================
module div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;

    // r_dvd starts as the dividend magnitude; its MSB feeds the partial
    // remainder each iteration while quotient bits enter at the LSB, so
    // after WIDTH iterations it holds the unsigned quotient.
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;
    logic [CNT_W-1:0] r_cnt;
    logic             r_qneg;
    logic             r_rneg;
    logic             r_dbz;

    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic             w_dvs_zero;
    logic             w_early;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nxt;

    // Operand magnitudes. Negating the most-negative value wraps to itself,
    // which reads correctly as 2^(WIDTH-1) when treated as unsigned.
    assign w_dvd_neg  = signed_mode & dividend[WIDTH-1];
    assign w_dvs_neg  = signed_mode & divisor[WIDTH-1];
    assign w_dvd_mag  = w_dvd_neg ? -dividend : dividend;
    assign w_dvs_mag  = w_dvs_neg ? -divisor  : divisor;
    assign w_dvs_zero = (divisor == '0);

`ifdef DIV_SEQ_EARLY_EXIT_EN
    assign w_early = !w_dvs_zero && (w_dvd_mag < w_dvs_mag);
`else
    assign w_early = 1'b0;
`endif

    // One restoring step. The shifted partial remainder needs WIDTH+1 bits;
    // the kept remainder is always below the divisor and fits in WIDTH bits.
    assign w_shift   = {r_rem, r_dvd[WIDTH-1]};
    assign w_ge      = (w_shift >= {1'b0, r_dvs});
    assign w_rem_nxt = w_ge ? WIDTH'(w_shift - {1'b0, r_dvs}) : w_shift[WIDTH-1:0];

    assign busy = (r_state != ST_IDLE);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_dvs_zero || w_early) begin
                        w_state_nxt = ST_FIX;
                    end else begin
                        w_state_nxt = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_FIX;
                end
            end
            ST_FIX: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_qneg      <= 1'b0;
            r_rneg      <= 1'b0;
            r_dbz       <= 1'b0;
            done        <= 1'b0;
            q           <= '0;
            r           <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_dvs <= w_dvs_mag;
                        r_cnt <= c_cnt_init;
                        r_dbz <= w_dvs_zero;
                        if (w_dvs_zero || w_early) begin
                            // Final values are loaded directly so FIX passes
                            // them through unchanged: q is all ones for a zero
                            // divisor and zero for an early exit, r is the raw
                            // dividend in both cases.
                            r_dvd  <= w_dvs_zero ? '1 : '0;
                            r_rem  <= dividend;
                            r_qneg <= 1'b0;
                            r_rneg <= 1'b0;
                        end else begin
                            r_dvd  <= w_dvd_mag;
                            r_rem  <= '0;
                            r_qneg <= w_dvd_neg ^ w_dvs_neg;
                            r_rneg <= w_dvd_neg;
                        end
                    end
                end
                ST_CALC: begin
                    r_rem <= w_rem_nxt;
                    r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt - c_cnt_one;
                end
                ST_FIX: begin
                    q           <= r_qneg ? -r_dvd : r_dvd;
                    r           <= r_rneg ? -r_rem : r_rem;
                    div_by_zero <= r_dbz;
                    done        <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_seq
// Purpose  : Self-checking bench for div_seq (WIDTH=32). Expected results
//            come from plain SystemVerilog signed/unsigned division with the
//            divide-by-zero and overflow rules applied on top.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_seq;

    localparam int W = 32;
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         signed_mode;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         div_by_zero;

    int n_cmp = 0;
    int n_bad = 0;

    div_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .q           (q),
        .r           (r),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] eq, output logic [W-1:0] er,
                                  output logic edz);
        edz = (b == '0);
        if (b == '0) begin
            eq = '1;
            er = a;
        end else if (sm) begin
            if (a == MIN_NEG && b == '1) begin
                eq = MIN_NEG;
                er = '0;
            end else begin
                eq = W'($signed(a) / $signed(b));
                er = W'($signed(a) % $signed(b));
            end
        end else begin
            eq = a / b;
            er = a % b;
        end
    endfunction

    function automatic int exp_lat(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] ma;
        logic [W-1:0] mb;
        ma = (sm && a[W-1]) ? -a : a;
        mb = (sm && b[W-1]) ? -b : b;
        if (b == '0) return 1;
`ifdef DIV_SEQ_EARLY_EXIT_EN
        if (ma < mb) return 1;
`else
        if (ma < mb && ma > mb) return 1;
`endif
        return W + 1;
    endfunction

    // Edges counted from the accept edge until done is seen; bounded.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 200);
    endtask

    task automatic accept(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start       = 1'b1;
        signed_mode = sm;
        dividend    = a;
        divisor     = b;
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        signed_mode = 1'($urandom);
        dividend    = $urandom;
        divisor     = $urandom;
    endtask

    task automatic check_res(input string tag, input logic sm, input logic [W-1:0] a,
                             input logic [W-1:0] b);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         edz;
        model(sm, a, b, eq, er, edz);
        check({tag, ".q"}, q, eq);
        check({tag, ".r"}, r, er);
        check({tag, ".dbz"}, div_by_zero, edz);
    endtask

    task automatic run_op(input string tag, input logic sm, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        int n;
        accept(sm, a, b);
        start = 1'b0;
        scramble();
        check({tag, ".busy"}, busy, 1);
        wait_done(n);
        check({tag, ".lat"}, n, exp_lat(sm, a, b));
        check({tag, ".busy_done"}, busy, 0);
        check_res(tag, sm, a, b);
        @(posedge clk);
        #1;
        check({tag, ".pulse"}, done, 0);
    endtask

    initial begin
        int n;
        int ndone;
        logic         sm;
        logic [W-1:0] a;
        logic [W-1:0] b;

        rst = 1'b1;
        start = 1'b0;
        signed_mode = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.q", q, 0);
        check("rst.r", r, 0);
        check("rst.dbz", div_by_zero, 0);
        rst = 1'b0;

        // Directed cases
        run_op("u100_7", 1'b0, 32'd100, 32'd7);
        run_op("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_op("s7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        run_op("u5_0", 1'b0, 32'd5, 32'd0);
        run_op("u9_3", 1'b0, 32'd9, 32'd3);
        run_op("s_ovf", 1'b1, MIN_NEG, 32'hFFFF_FFFF);
        run_op("umax_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
        run_op("u3_10", 1'b0, 32'd3, 32'd10);
        run_op("s0_-5", 1'b1, 32'd0, 32'hFFFF_FFFB);
        run_op("s-9_0", 1'b1, 32'hFFFF_FFF7, 32'd0);

        // Start held high during busy with other operands: ignored.
        accept(1'b0, 32'd1000, 32'd9);
        for (int i = 0; i < 10; i++) begin
            dividend = $urandom;
            divisor  = $urandom;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        wait_done(n);
        check("hold.lat", n + 10, W + 1);
        check_res("hold", 1'b0, 32'd1000, 32'd9);

        // Start in the done cycle is accepted; dones are W+2 cycles apart.
        accept(1'b0, 32'd777, 32'd5);
        start = 1'b0;
        wait_done(n);
        check_res("b2b1", 1'b0, 32'd777, 32'd5);
        start    = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble();
        wait_done(n);
        check("b2b.gap", n + 1, W + 2);
        check_res("b2b2", 1'b0, 32'd1000, 32'd3);

        // Reset in mid-calculation aborts without a done.
        accept(1'b1, 32'd123456, 32'd11);
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort.busy", busy, 0);
        check("abort.done", done, 0);
        check("abort.q", q, 0);
        check("abort.r", r, 0);
        check("abort.dbz", div_by_zero, 0);
        ndone = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("abort.nodone", ndone, 0);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            sm = 1'($urandom);
            a  = $urandom;
            case ($urandom_range(0, 6))
                0: b = '0;
                1: b = W'($urandom_range(1, 15));
                2: begin
                    sm = 1'b1;
                    a  = MIN_NEG;
                    b  = '1;
                end
                3: begin
                    b = $urandom;
                    a = W'($urandom_range(0, 100));
                end
                default: b = $urandom;
            endcase
            run_op($sformatf("rnd%0d", i), sm, a, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
